uart_word_rx_fifo: RTL and testbench

//  Packs the byte stream from the UART byte receiver into words of BYTES bytes, in either byte order.
//  If the line goes idle mid-word, a baud-scaled timeout flushes the partial word, tagged with its byte count.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 56 +++++
 rtl/uart_word_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_word_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART word receive path.
package uart_rx_pkg;

    localparam int TIMER_W  = 20;
    localparam int NBYTES_W = 5;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } asm_state_e;

    // Whole clocks per bit; the division truncates and folds to a constant per baud code.
    function automatic int unsigned clks_per_bit(input logic [2:0] baud_set,
                                                 input int unsigned clk_freq);
        int unsigned baud;
        case (baud_set)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            default: baud = 115200;
        endcase
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO; head entry is visible whenever the FIFO is not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Storage is not reset, so an empty FIFO presents zeros rather than stale data.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_word_rx_fifo.sv
// Packs received UART bytes into words, flushes partial words after an idle timeout,
// and queues finished words for a valid/ready consumer.
module uart_word_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int          BYTES        = 2,
    parameter int          MSB_FIRST    = 1,
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned TIMEOUT_BITS = 30,
    parameter int          OUT_DEPTH    = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [2:0]            baud_set,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic [8*BYTES-1:0]    out_data,
    output logic [NBYTES_W-1:0]   out_nbytes,
    output logic                  out_partial,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  drop_pulse,
    output logic                  overflow
);

    localparam int DW = 8 * BYTES;
    localparam int EW = DW + NBYTES_W + 1;
    localparam logic [NBYTES_W-1:0] FULL_COUNT = NBYTES_W'(BYTES);
    localparam logic [NBYTES_W-1:0] COUNT_ONE  = NBYTES_W'(1);
    localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);

    asm_state_e          state_q, state_d;
    logic [NBYTES_W-1:0] count_q, count_d;
    logic [DW-1:0]       word_q, word_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                drop_q;
    logic                overflow_q;

    logic [DW-1:0]       merged;
    logic [31:0]         thresh_m1;
    logic                timer_hit;
    logic                push;
    logic [DW-1:0]       push_word;
    logic [NBYTES_W-1:0] push_nbytes;
    logic                push_partial;
    logic                drop;

    logic [EW-1:0]       fifo_wr_data;
    logic [EW-1:0]       fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;

    // Word with the incoming byte placed; unfilled bytes stay zero because the
    // word register is cleared whenever the assembler returns to idle.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            if (BYTES == 1) begin : g_one
                assign merged = byte_data;
            end else begin : g_shift
                assign merged = {word_q[DW-9:0], byte_data};
            end
        end else begin : g_lsb
            for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
                assign merged[8*gi +: 8] = (count_q == NBYTES_W'(gi)) ? byte_data
                                                                      : word_q[8*gi +: 8];
            end
        end
    endgenerate

    // Threshold follows baud_set live, so a rate change applies at the next compare.
    assign thresh_m1 = TIMEOUT_BITS * clks_per_bit(baud_set, CLK_FREQ) - 32'd1;
    assign timer_hit = ({{(32-TIMER_W){1'b0}}, timer_q} == thresh_m1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_d       = word_q;
        timer_d      = timer_q;
        push         = 1'b0;
        push_word    = word_q;
        push_nbytes  = count_q;
        push_partial = 1'b0;

        if (byte_valid) begin
            timer_d = '0;
            if (count_q + COUNT_ONE == FULL_COUNT) begin
                push        = 1'b1;
                push_word   = merged;
                push_nbytes = FULL_COUNT;
                state_d     = ST_IDLE;
                count_d     = '0;
                word_d      = '0;
            end else begin
                state_d = ST_COLLECT;
                count_d = count_q + COUNT_ONE;
                word_d  = merged;
            end
        end else if (state_q == ST_COLLECT) begin
            if (timer_hit) begin
                push         = 1'b1;
                push_partial = 1'b1;
                state_d      = ST_IDLE;
                count_d      = '0;
                word_d       = '0;
                timer_d      = '0;
            end else begin
                timer_d = timer_q + TIMER_ONE;
            end
        end
    end

    // A full FIFO still takes the word if the consumer pops in the same cycle.
    assign drop = push && fifo_full && !out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_q     <= '0;
            timer_q    <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_q     <= word_d;
            timer_q    <= timer_d;
            drop_q     <= drop;
            overflow_q <= overflow_q | drop;
        end
    end

    assign fifo_wr_data = {push_word, push_nbytes, push_partial};

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en_i   (push),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign out_data    = fifo_rd_data[EW-1 -: DW];
    assign out_nbytes  = fifo_rd_data[NBYTES_W:1];
    assign out_partial = fifo_rd_data[0];
    assign out_valid   = !fifo_empty;
    assign drop_pulse  = drop_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_word_rx_fifo.sv
// Randomized and directed bench for uart_word_rx_fifo, checked against a queue-based model
// of byte packing, idle flush and the output FIFO (both byte orders run side by side).
module tb_uart_word_rx_fifo;

    localparam int BYTES = 2;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [2:0]  baud_set;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        out_ready;

    logic [15:0] m_data, l_data;
    logic [4:0]  m_nb, l_nb;
    logic        m_part, l_part, m_valid, l_valid, m_drop, l_drop, m_ovf, l_ovf;

    always #5 Clk = ~Clk;

    uart_word_rx_fifo #(.BYTES(BYTES), .MSB_FIRST(1), .OUT_DEPTH(DEPTH)) dut_msb (
        .Clk(Clk), .Rst(Rst), .baud_set(baud_set), .byte_data(byte_data),
        .byte_valid(byte_valid), .out_data(m_data), .out_nbytes(m_nb),
        .out_partial(m_part), .out_valid(m_valid), .out_ready(out_ready),
        .drop_pulse(m_drop), .overflow(m_ovf)
    );

    uart_word_rx_fifo #(.BYTES(BYTES), .MSB_FIRST(0), .OUT_DEPTH(DEPTH)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .baud_set(baud_set), .byte_data(byte_data),
        .byte_valid(byte_valid), .out_data(l_data), .out_nbytes(l_nb),
        .out_partial(l_part), .out_valid(l_valid), .out_ready(out_ready),
        .drop_pulse(l_drop), .overflow(l_ovf)
    );

    typedef struct {
        logic [15:0] dm;
        logic [15:0] dl;
        int          nb;
        bit          part;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] pend[$];
    int         since;
    bit         e_drop;
    bit         e_ovf;
    int         n_vec;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, req, $time);
        end
    endtask

    function automatic int thr(input logic [2:0] b);
        int rate;
        case (b)
            3'd0:    rate = 9600;
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            default: rate = 115200;
        endcase
        return 30 * (50000000 / rate);
    endfunction

    function automatic ent_t pack(input bit part);
        ent_t e;
        e.dm = '0;
        e.dl = '0;
        for (int i = 0; i < pend.size(); i++) begin
            e.dm = (e.dm << 8) | {8'h00, pend[i]};
            e.dl = e.dl | (16'(pend[i]) << (8 * i));
        end
        e.nb   = pend.size();
        e.part = part;
        return e;
    endfunction

    // What the block should have done at the clock edge just taken.
    task automatic model_edge(input bit bv, input logic [7:0] bd, input bit rdy, input bit rst);
        bit   have;
        bit   popped;
        int   pre;
        ent_t w;
        have   = 0;
        popped = 0;
        e_drop = 0;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            since = 0;
            e_ovf = 0;
            return;
        end
        pre = exp_q.size();
        if (rdy && pre > 0) begin
            void'(exp_q.pop_front());
            popped = 1;
        end
        if (bv) begin
            pend.push_back(bd);
            since = 0;
            if (pend.size() == BYTES) begin
                w    = pack(1'b0);
                have = 1;
                pend.delete();
            end
        end else if (pend.size() > 0) begin
            since++;
            if (since == thr(baud_set)) begin
                w     = pack(1'b1);
                have  = 1;
                since = 0;
                pend.delete();
            end
        end
        if (have) begin
            if (pre == DEPTH && !popped) begin
                e_drop = 1;
                e_ovf  = 1;
            end else begin
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic compare_all();
        bit v;
        v = (exp_q.size() > 0);
        check("msb_valid", m_valid, v);
        check("lsb_valid", l_valid, v);
        if (v) begin
            check("msb_data", m_data, exp_q[0].dm);
            check("lsb_data", l_data, exp_q[0].dl);
            check("msb_nbytes", m_nb, exp_q[0].nb);
            check("lsb_nbytes", l_nb, exp_q[0].nb);
            check("msb_partial", m_part, exp_q[0].part);
            check("lsb_partial", l_part, exp_q[0].part);
        end
        check("msb_drop", m_drop, e_drop);
        check("lsb_drop", l_drop, e_drop);
        check("msb_ovf", m_ovf, e_ovf);
        check("lsb_ovf", l_ovf, e_ovf);
    endtask

    task automatic step(input bit bv, input logic [7:0] bd, input bit rdy, input bit rst);
        Rst        = rst;
        byte_valid = bv;
        byte_data  = bd;
        out_ready  = rdy;
        @(posedge Clk);
        model_edge(bv, bd, rdy, rst);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        since      = 0;
        e_drop     = 0;
        e_ovf      = 0;
        baud_set   = 3'd4;
        Rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        out_ready  = 1'b0;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 16'h0000);
        check("rst_nbytes", m_nb, 5'd0);
        check("rst_partial", m_part, 1'b0);
        check("rst_drop", m_drop, 1'b0);
        check("rst_ovf", m_ovf, 1'b0);

        // Two bytes 100 clocks apart form one full word in each byte order
        step(1'b1, 8'h12, 1'b0, 1'b0);
        idle(99, 1'b0);
        check("t1_not_yet", m_valid, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0);
        check("t1_valid", m_valid, 1'b1);
        check("t1_msb_data", m_data, 16'h1234);
        check("t1_lsb_data", l_data, 16'h3412);
        check("t1_nbytes", m_nb, 5'd2);
        check("t1_partial", m_part, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_popped", m_valid, 1'b0);

        // Lone byte flushed as a partial word exactly 13020 clocks later
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        idle(13018, 1'b0);
        check("t3_no_flush_13018", m_valid, 1'b0);
        idle(1, 1'b0);
        check("t3_no_flush_13019", m_valid, 1'b0);
        idle(1, 1'b0);
        check("t3_flush_valid", m_valid, 1'b1);
        check("t3_msb_data", m_data, 16'h00AB);
        check("t3_lsb_data", l_data, 16'h00AB);
        check("t3_nbytes", m_nb, 5'd1);
        check("t3_partial", m_part, 1'b1);
        drain();

        // Five full words with the consumer stalled: the fifth is dropped
        for (int w = 0; w < 5; w++) begin
            step(1'b1, 8'(8'h10 + 2 * w), 1'b0, 1'b0);
            step(1'b1, 8'(8'h11 + 2 * w), 1'b0, 1'b0);
            if (w < 4) check("t4_no_drop", m_drop, 1'b0);
        end
        check("t4_drop", m_drop, 1'b1);
        check("t4_ovf", m_ovf, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_drop_once", m_drop, 1'b0);
        check("t4_ovf_sticky", m_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_valid", m_valid, 1'b1);
            check("t4_drain_data", m_data, {8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)});
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("t4_empty", m_valid, 1'b0);

        // Second byte lands on the would-be timeout cycle: it wins
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(13019, 1'b0);
        check("t5_no_flush", m_valid, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        check("t5_valid", m_valid, 1'b1);
        check("t5_data", m_data, 16'h5AC3);
        check("t5_nbytes", m_nb, 5'd2);
        check("t5_partial", m_part, 1'b0);
        drain();

        // Reset mid-word discards the held byte and clears the sticky flag
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_valid", m_valid, 1'b0);
        check("t6_ovf", m_ovf, 1'b0);
        check("t6_data", m_data, 16'h0000);
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        check("t6_word", m_data, 16'h2143);
        check("t6_nbytes", m_nb, 5'd2);
        check("t6_partial", m_part, 1'b0);
        drain();

        // Random traffic with varying consumer throughput
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 800; i++) begin
                bit rdy;
                if (pend.size() == 0 && $urandom_range(0, 199) == 0)
                    baud_set = 3'($urandom_range(3, 7));
                case (ph % 3)
                    0:       rdy = ($urandom_range(0, 3) != 0);
                    1:       rdy = ($urandom_range(0, 7) == 0);
                    default: rdy = $urandom_range(0, 1) != 0;
                endcase
                step($urandom_range(0, 3) == 0, 8'($urandom), rdy, $urandom_range(0, 1999) == 0);
            end
            if (ph == 2 || ph == 4) begin
                if (pend.size() == 0) baud_set = 3'd4;
                step(1'b1, 8'($urandom), 1'b1, 1'b0);
                idle(13100, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
